// File: rtl/mem_refill_ctrl.sv
// Refill controller: arbitrates I-side and D-side misses onto one 32-bit word
// memory port, assembling 4-word lines for refills and passing single-word writes.
module mem_refill_ctrl #(
    parameter int unsigned TIMEOUT   = 255,
    parameter bit          DATA_PRIO = 1'b1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_req,
    input  logic [31:0]  i_addr,
    input  logic         d_req,
    input  logic         d_we,
    input  logic [31:0]  d_addr,
    input  logic [31:0]  d_wdata,
    output logic         o_i_valid,
    output logic         o_d_valid,
    output logic [127:0] o_line,
    output logic         o_err,
    output logic         o_busy,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_wdata,
    input  logic         mem_ack,
    input  logic [31:0]  mem_rdata
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t       state, state_nxt;
    logic [1:0]   beat;
    logic [15:0]  tcnt;
    logic         svc_d;
    logic         take_i, take_d, tmo;
    logic [31:4]  req_addr;
    logic         unused_addr_bits;

    assign unused_addr_bits = ^{i_addr[3:0], d_addr[1:0]};

    assign o_busy    = (state != IDLE);
    assign o_i_valid = (state == DONE) && !svc_d;
    assign o_d_valid = (state == DONE) && svc_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_nxt = state;
        take_i    = 1'b0;
        take_d    = 1'b0;
        tmo       = 1'b0;
        req_addr  = i_addr[31:4];
        case (state)
            IDLE: begin
                take_d = d_req && (DATA_PRIO || !i_req);
                take_i = i_req && !take_d;
                if (take_d) begin
                    req_addr  = d_addr[31:4];
                    state_nxt = d_we ? WR : RD;
                end else if (take_i) begin
                    state_nxt = RD;
                end
            end
            RD, WR: begin
                if (mem_ack) begin
                    if (state == WR || beat == 2'd3) state_nxt = DONE;
                end else if (tcnt == TMO_LAST) begin
                    tmo       = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat      <= 2'd0;
            tcnt      <= 16'd0;
            svc_d     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            o_line    <= '0;
            o_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_i || take_d) begin
                        svc_d   <= take_d;
                        mem_req <= 1'b1;
                        mem_we  <= take_d && d_we;
                        tcnt    <= 16'd0;
                        beat    <= 2'd0;
                        if (take_d && d_we) begin
                            mem_addr  <= {d_addr[31:2], 2'b00};
                            mem_wdata <= d_wdata;
                        end else begin
                            mem_addr  <= {req_addr, 4'h0};
                        end
                    end
                end
                RD, WR: begin
                    if (mem_ack) begin
                        tcnt <= 16'd0;
                        if (state == RD) o_line[{beat, 5'd0} +: 32] <= mem_rdata;
                        if (state == WR || beat == 2'd3) begin
                            mem_req <= 1'b0;
                            mem_we  <= 1'b0;
                        end else begin
                            // Next beat issues straight away, keeping mem_req high.
                            beat          <= beat + 2'd1;
                            mem_addr[3:2] <= beat + 2'd1;
                        end
                    end else if (tmo) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        o_err   <= 1'b1;
                        o_line  <= '0;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                DONE:    o_err <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_refill_ctrl.sv
// Self-checking bench for mem_refill_ctrl: table vectors, hand-written corner
// sequences and randomized transactions against a transaction-level memory model.
module tb_mem_refill_ctrl;

    localparam int TMO = 8;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0]  i_addr = '0, d_addr = '0, d_wdata = '0;
    logic         o_i_valid, o_d_valid, o_err, o_busy;
    logic [127:0] o_line;
    logic         mem_req, mem_we, mem_ack;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    int   ack_wait  = 0;     // cycles of wait per beat; negative = never ack
    bit   ack_force = 1'b0;
    int   ack_cnt   = 0;
    logic ack_gen   = 1'b0;

    always #5 clk = ~clk;

    mem_refill_ctrl #(.TIMEOUT(TMO), .DATA_PRIO(1'b1)) dut (
        .clk(clk), .rstn(rstn),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .o_i_valid(o_i_valid), .o_d_valid(o_d_valid), .o_line(o_line),
        .o_err(o_err), .o_busy(o_busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    // Memory contents: a fixed pattern around 0x1230, a hash elsewhere.
    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (a[31:4] == 28'h0000123) return 32'hA0 + {30'd0, a[3:2]};
        return (a * 32'h9E37_79B1) ^ 32'h0F1E_2D3C;
    endfunction

    function automatic logic [127:0] model_line(input logic [31:0] a);
        logic [31:0] b;
        b = {a[31:4], 4'h0};
        return {rd_word(b + 32'd12), rd_word(b + 32'd8), rd_word(b + 32'd4), rd_word(b)};
    endfunction

    assign mem_rdata = rd_word(mem_addr);
    assign mem_ack   = ack_gen | ack_force;

    // Memory responder: decides the ack for the coming edge shortly after each edge.
    always @(posedge clk) begin
        #2;
        if (!mem_req || ack_wait < 0) begin
            ack_cnt <= 0;
            ack_gen <= 1'b0;
        end else if (ack_cnt >= ack_wait) begin
            ack_cnt <= 0;
            ack_gen <= 1'b1;
        end else begin
            ack_cnt <= ack_cnt + 1;
            ack_gen <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issues one request (starting from IDLE at a falling edge) and follows it to its valid pulse.
    task automatic run_txn(input bit is_d, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input int wt, input int exp_lat,
                           input bit exp_err, input string tag);
        logic [127:0] line_before, exp_line;
        logic [31:0]  exp_a;
        int           nacks, k;
        bit           beat_ok, seen;
        line_before = o_line;
        exp_line    = exp_err ? 128'd0 : (we ? line_before : model_line(addr));
        nacks = 0; k = 0; beat_ok = 1'b1; seen = 1'b0;
        ack_wait = wt;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        while (!seen && k < 300) begin
            @(negedge clk);
            k++;
            if (mem_req) begin
                exp_a = we ? {addr[31:2], 2'b00} : ({addr[31:4], 4'h0} + 32'(4 * nacks));
                if (mem_addr !== exp_a || mem_we !== we || (we && mem_wdata !== wdata)) beat_ok = 1'b0;
                if (mem_ack) nacks++;
            end
            if (o_i_valid || o_d_valid) begin
                seen = 1'b1;
                check({tag, " side"}, {o_d_valid, o_i_valid}, is_d ? 2'b10 : 2'b01);
                check({tag, " err"}, o_err, exp_err);
                check({tag, " line"}, o_line, exp_line);
                check({tag, " latency"}, k - 1, exp_lat);
                check({tag, " mem_req low"}, mem_req, 1'b0);
                i_req = 1'b0; d_req = 1'b0;
            end else if (k == 1) begin
                i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
            end
        end
        if (!seen) begin
            check({tag, " valid within bound"}, 1'b0, 1'b1);
            i_req = 1'b0; d_req = 1'b0;
        end
        check({tag, " beats"}, beat_ok, 1'b1);
        check({tag, " ack count"}, nacks, exp_err ? 0 : (we ? 1 : 4));
        @(negedge clk);
        check({tag, " idle after"}, {o_busy, o_i_valid, o_d_valid}, 3'b000);
    endtask

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wt;
        int          exp_lat;
        bit          exp_err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h0000_1234, 32'h0,          0, 4,  1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0047, 32'hDEAD_BEEF,  3, 4,  1'b0};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_5678, 32'h0,          2, 12, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_9ABC, 32'h0,          1, 8,  1'b0};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_0102, 32'h1234_5678,  0, 1,  1'b0};

        #3;
        check("reset ctrl outputs", {o_i_valid, o_d_valid, o_err, o_busy, mem_req, mem_we}, 6'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        check("reset mem_wdata", mem_wdata, 32'd0);
        check("reset line", o_line, 128'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i].is_d, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wt,
                    vecs[i].exp_lat, vecs[i].exp_err, $sformatf("vec%0d", i));
            if (i == 0)
                check("vec0 line const", o_line, 128'h000000A3_000000A2_000000A1_000000A0);
        end

        // Simultaneous requests: data side first, instruction side accepted after DONE.
        begin
            int nd, ni, kd, ki;
            logic [127:0] ld, li;
            nd = 0; ni = 0; kd = -1; ki = -1; ld = '0; li = '0;
            ack_wait = 0;
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
            i_req = 1'b1; i_addr = 32'h2000;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                if (o_d_valid) begin
                    nd++;
                    if (kd < 0) begin kd = k; ld = o_line; end
                    d_req = 1'b0;
                end
                if (o_i_valid) begin
                    ni++;
                    if (ki < 0) begin ki = k; li = o_line; end
                    i_req = 1'b0;
                end
            end
            i_req = 1'b0; d_req = 1'b0;
            check("prio d pulses", nd, 1);
            check("prio i pulses", ni, 1);
            check("prio d first latency", kd - 1, 4);
            check("prio i after d gap", ki - kd, 6);
            check("prio d line", ld, model_line(32'h80));
            check("prio i line", li, model_line(32'h2000));
        end

        // Timeout with no ack, then a late ack that must be ignored.
        run_txn(1'b0, 1'b0, 32'h0000_3000, 32'h0, -1, TMO, 1'b1, "timeout");
        begin
            bit quiet;
            quiet = 1'b1;
            ack_force = 1'b1;
            repeat (3) begin
                @(negedge clk);
                if (o_i_valid || o_d_valid || o_busy || mem_req || o_err) quiet = 1'b0;
            end
            ack_force = 1'b0;
            check("late ack ignored", quiet, 1'b1);
            check("late ack line", o_line, 128'd0);
        end

        // Reset in the middle of a refill.
        begin
            bit no_valid;
            no_valid = 1'b1;
            ack_wait = 0;
            i_req = 1'b1; i_addr = 32'h0000_4000;
            @(posedge clk);
            @(posedge clk);
            @(posedge clk);
            #3 rstn = 1'b0;
            #1;
            check("mid reset mem_req", mem_req, 1'b0);
            check("mid reset busy", o_busy, 1'b0);
            check("mid reset line", o_line, 128'd0);
            i_req = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (o_i_valid || o_d_valid) no_valid = 1'b0;
            end
            rstn = 1'b1;
            @(negedge clk);
            if (o_i_valid || o_d_valid) no_valid = 1'b0;
            check("mid reset no valid", no_valid, 1'b1);
            run_txn(1'b0, 1'b0, 32'h0000_4000, 32'h0, 0, 4, 1'b0, "after reset");
        end

        // Randomized single transactions.
        for (int r = 0; r < 20; r++) begin
            bit          is_d, we;
            logic [31:0] addr, wdata;
            int          wt;
            is_d  = 1'($urandom_range(0, 1));
            we    = is_d & 1'($urandom_range(0, 1));
            addr  = $urandom;
            wdata = $urandom;
            wt    = $urandom_range(0, 3);
            run_txn(is_d, we, addr, wdata, wt, we ? (wt + 1) : (4 * (wt + 1)), 1'b0,
                    $sformatf("rand%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_refill_ctrl.md
Name: mem_refill_ctrl

Overview:
Memory-side refill controller for the MIPS core's instruction and data caches. It sits directly downstream of the CPU top level. It consumes the instruction-miss and data-miss requests (addresses, write data) and produces the 128-bit refill lines that the core takes on its ii_miss_data / id_miss_data inputs. It arbitrates the two requesters onto one 32-bit word memory port and assembles 4-word lines over four sequential beats; data-side writes go straight through as single-word writes.

Parameters:
TIMEOUT, 255, max cycles one memory beat may wait for mem_ack before the transaction aborts (1..65535)
DATA_PRIO, 1, 1 = data side wins simultaneous requests; 0 = instruction side wins

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
i_req  in  1  instruction-cache miss request; held high until o_i_valid
i_addr  in  32  instruction miss address; bits [3:0] ignored
d_req  in  1  data-cache miss/write request; held high until o_d_valid
d_we  in  1  1 = single-word write, 0 = line refill
d_addr  in  32  data address; [3:0] ignored for refill, [1:0] ignored for write
d_wdata  in  32  write data
o_i_valid  out  1  one-cycle pulse: instruction transaction complete
o_d_valid  out  1  one-cycle pulse: data transaction complete
o_line  out  128  assembled line; drives both ii_miss_data and id_miss_data
o_err  out  1  high together with a valid pulse when the transaction timed out
o_busy  out  1  high whenever state != IDLE
mem_req  out  1  memory beat request, registered
mem_we  out  1  beat is a write
mem_addr  out  32  word address of the current beat
mem_wdata  out  32  write data of the current beat
mem_ack  in  1  beat complete; sampled on rising edge while mem_req=1
mem_rdata  in  32  read word, valid in the mem_ack cycle

Behaviour:
- Reset (asynchronous, any state): state=IDLE, all outputs 0, o_line=0, beat counter=0, timeout counter=0. Reset mid-transaction aborts it silently: mem_req drops immediately and no valid pulse is produced.
- States: IDLE, RD, WR, DONE.
- IDLE: acceptance happens on a rising edge with a request high.
  - Winner chosen by DATA_PRIO when both requests are high.
  - Address and d_wdata are latched on acceptance; the requester's inputs may change afterwards.
  - Refill acceptance -> RD, beat=0, mem_req=1, mem_we=0, mem_addr={addr[31:4],4'b0}.
  - Write acceptance -> WR, mem_req=1, mem_we=1, mem_addr={d_addr[31:2],2'b00}, mem_wdata=d_wdata.
- RD: on an edge with mem_ack=1:
  - mem_rdata is stored into o_line[32*beat+31:32*beat].
  - If beat<3: beat increments and mem_addr={base[31:4],beat+1,2'b00}; mem_req stays high with no bubble.
  - If beat==3: -> DONE, mem_req=0.
- WR: on an edge with mem_ack=1 -> DONE, mem_req=0, mem_we=0. o_line is unchanged.
- Timeout: the counter clears on each ack and on acceptance, and increments every RD/WR cycle without ack.
  - When it reaches TIMEOUT: -> DONE, o_err=1, o_line=0, mem_req=0.
  - A late mem_ack after the abort is ignored.
- DONE: exactly one cycle.
  - o_i_valid or o_d_valid is 1 for the serviced side only; o_err is valid in the same cycle.
  - Next state is IDLE; o_err clears.
- The earliest next acceptance is the edge leaving IDLE, one cycle after DONE.
  - A requester whose req is still high in IDLE is re-accepted. Requesters must drop req the cycle after their valid pulse.
- Latency with mem_ack tied high: request accepted at edge N, beats acked at edges N+1..N+4, valid high between edges N+4 and N+5.
  - A refill costs 6 cycles request-to-next-acceptance; a write costs 3.
- o_line holds its value until the next refill's first ack. Partially written words during a refill are not observable as valid.
- A losing requester simply waits; no starvation guarantee beyond the fixed priority.

Test Plan:
1. Refill, ack tied 1: i_req=1, i_addr=0x0000_1234; mem_rdata returns 0xA0,0xA1,0xA2,0xA3 -> mem_addr 0x1230,0x1234,0x1238,0x123C on consecutive cycles; o_i_valid pulses at cycle N+4; o_line=0x000000A3_000000A2_000000A1_000000A0; o_err=0.
2. Simultaneous requests, DATA_PRIO=1: i_req=d_req=1 (d_we=0, d_addr=0x80) -> data refill of 0x80..0x8C completes first with o_d_valid; instruction refill is accepted on the edge after DONE; each side gets exactly one valid pulse.
3. Write: d_req=1, d_we=1, d_addr=0x0000_0047, d_wdata=0xDEADBEEF, ack delayed 3 cycles -> mem_we=1, mem_addr=0x44, mem_wdata=0xDEADBEEF held stable until ack; o_d_valid one cycle later; o_line unchanged.
4. Wait states: mem_ack low 2 cycles per beat -> mem_addr stable while waiting; o_line correct; o_i_valid 12 cycles after acceptance.
5. Timeout, TIMEOUT=8: mem_ack never asserted -> after 8 RD cycles o_i_valid=1 and o_err=1 for one cycle, o_line=0, mem_req=0; a late ack is ignored.
6. Reset mid-refill: rstn low after beat 1 -> mem_req and o_busy drop asynchronously, no valid pulse; after release a fresh request completes normally.
